// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the memory copy/fill engine.
// The enum is the engine's FSM; sizes describe the attached data memory.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic MODE_COPY  = 1'b0;
  localparam logic MODE_FILL  = 1'b1;
  localparam int   WORD_BYTES = 4;
  localparam int   MEM_WORDS  = 64;

endpackage

// File: rtl/mem_copy_engine.sv
// Word copy/fill initiator: copy costs 2 cycles/word, fill 1 cycle/word, done pulses one cycle after the last write.
// No backpressure; start is only sampled in IDLE and the memory is owned exclusively while busy.
module mem_copy_engine
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_write,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam logic [31:0]      STEP = 32'(WORD_BYTES);
  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

  state_t           state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      fill_q;
  logic [31:0]      hold_q;
  logic [LEN_W-1:0] len_q;
  logic             last_word;

  assign last_word = (words_done + ONE) == len_q;

  // Address, count and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q      <= '0;
      dst_q      <= '0;
      fill_q     <= '0;
      hold_q     <= '0;
      len_q      <= '0;
      words_done <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q      <= {src_addr[31:2], 2'b00};
            dst_q      <= {dst_addr[31:2], 2'b00};
            fill_q     <= fill_data;
            len_q      <= len;
            words_done <= '0;
          end
        end
        ST_READ: hold_q <= mem_read_data;
        ST_WRITE: begin
          src_q      <= src_q + STEP;
          dst_q      <= dst_q + STEP;
          words_done <= words_done + ONE;
        end
        ST_FILL: begin
          dst_q      <= dst_q + STEP;
          words_done <= words_done + ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0)             state <= ST_DONE;
            else if (mode == MODE_FILL) state <= ST_FILL;
            else                       state <= ST_READ;
          end
        end
        ST_READ:  state <= ST_WRITE;
        ST_WRITE: state <= last_word ? ST_DONE : ST_READ;
        ST_FILL:  state <= last_word ? ST_DONE : ST_FILL;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs depend on state only, so reset kills the strobe immediately.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state)
      ST_READ: begin
        busy        = 1'b1;
        mem_address = src_q;
      end
      ST_WRITE: begin
        busy           = 1'b1;
        mem_write      = 1'b1;
        mem_address    = dst_q;
        mem_write_data = hold_q;
      end
      ST_FILL: begin
        busy           = 1'b1;
        mem_write      = 1'b1;
        mem_address    = dst_q;
        mem_write_data = fill_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine against a 64-word memory preloaded with word i = i.
// Timing is counted in cycles after the edge that samples start (cycle 1 = first cycle after it).
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [6:0]  len = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, mem_write;
  logic [6:0]  words_done;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:63];
  logic        preload_req = 1'b0;
  int          total = 0;
  int          bad = 0;

  mem_copy_engine #(.LEN_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .words_done(words_done),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address[7:2]];

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i);
    end else if (mem_write && mem_address[31:8] == 24'd0 && mem_address[1:0] == 2'b00) begin
      mem[mem_address[7:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload();
    @(negedge clk) preload_req = 1'b1;
    @(negedge clk) preload_req = 1'b0;
  endtask

  // Starts a transfer and watches until done or a cycle budget runs out.
  // inject_cyc > 0 pulses a conflicting start in that cycle.
  task automatic run_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input logic [6:0] l, input logic [31:0] f, input int inject_cyc,
                          output int done_cyc, output int busy_cnt, output int busy_first,
                          output int wr_cnt, output int wr_first);
    done_cyc = 0; busy_cnt = 0; busy_first = 0; wr_cnt = 0; wr_first = 0;
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (busy) begin busy_cnt++; if (busy_first == 0) busy_first = c; end
      if (mem_write) begin wr_cnt++; if (wr_first == 0) wr_first = c; end
      if (c == inject_cyc) begin
        start = 1'b1; mode = 1'b1; src_addr = 32'h40; dst_addr = 32'h0;
        len = 7'd2; fill_data = 32'h5555_5555;
      end else begin
        start = 1'b0;
      end
      if (done) begin done_cyc = c; break; end
    end
    start = 1'b0;
  endtask

  int dc, bc, bf, wc, wf;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_write_data", mem_write_data, 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    rst_n = 1'b1;

    // Basic copy 0x00 -> 0x80, 4 words
    preload();
    run_xfer(1'b0, 32'h00, 32'h80, 7'd4, 32'h0, 0, dc, bc, bf, wc, wf);
    chk("copy_done_cycle", 32'(dc), 32'd9);
    chk("copy_busy_cycles", 32'(bc), 32'd8);
    chk("copy_busy_first", 32'(bf), 32'd1);
    chk("copy_write_cycles", 32'(wc), 32'd4);
    chk("copy_first_write", 32'(wf), 32'd2);
    chk("copy_words_done", 32'(words_done), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("copy_w%0d", 32 + i), mem[32 + i], 32'(i));
    chk("copy_w36_untouched", mem[36], 32'd36);

    // Fill 0x10, 3 words
    preload();
    run_xfer(1'b1, 32'h0, 32'h10, 7'd3, 32'hDEAD_BEEF, 0, dc, bc, bf, wc, wf);
    chk("fill_done_cycle", 32'(dc), 32'd4);
    chk("fill_write_cycles", 32'(wc), 32'd3);
    chk("fill_first_write", 32'(wf), 32'd1);
    for (int i = 4; i < 7; i++) chk($sformatf("fill_w%0d", i), mem[i], 32'hDEAD_BEEF);
    chk("fill_w3_untouched", mem[3], 32'd3);
    chk("fill_w7_untouched", mem[7], 32'd7);

    // Zero length
    run_xfer(1'b0, 32'h0, 32'h20, 7'd0, 32'h0, 0, dc, bc, bf, wc, wf);
    chk("zero_done_cycle", 32'(dc), 32'd1);
    chk("zero_write_cycles", 32'(wc), 32'd0);
    chk("zero_busy_cycles", 32'(bc), 32'd0);
    chk("zero_w8_untouched", mem[8], 32'd8);

    // Misaligned source 0x03 treated as 0x00
    preload();
    run_xfer(1'b0, 32'h03, 32'h40, 7'd2, 32'h0, 0, dc, bc, bf, wc, wf);
    chk("misal_done_cycle", 32'(dc), 32'd5);
    chk("misal_w16", mem[16], 32'd0);
    chk("misal_w17", mem[17], 32'd1);

    // Conflicting start in cycle 3 of a copy
    preload();
    run_xfer(1'b0, 32'h00, 32'h80, 7'd4, 32'h0, 3, dc, bc, bf, wc, wf);
    chk("busy_start_done_cycle", 32'(dc), 32'd9);
    chk("busy_start_write_cycles", 32'(wc), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("busy_start_w%0d", 32 + i), mem[32 + i], 32'(i));
    chk("busy_start_w0", mem[0], 32'd0);
    chk("busy_start_w1", mem[1], 32'd1);
    @(negedge clk);
    chk("busy_start_idle_after", 32'(busy), 32'd0);

    // Forward overlap propagates word 0
    preload();
    run_xfer(1'b0, 32'h00, 32'h04, 7'd3, 32'h0, 0, dc, bc, bf, wc, wf);
    chk("ovl_done_cycle", 32'(dc), 32'd7);
    chk("ovl_w0", mem[0], 32'd0);
    for (int i = 1; i < 4; i++) chk($sformatf("ovl_w%0d", i), mem[i], 32'd0);
    chk("ovl_w4", mem[4], 32'd4);

    // Reset during the third WRITE of a 5-word copy
    preload();
    @(negedge clk);
    mode = 1'b0; src_addr = 32'h0; dst_addr = 32'h80; len = 7'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("rstmid_pre_write", 32'(mem_write), 32'd1);
    chk("rstmid_pre_addr", mem_address, 32'h88);
    rst_n = 1'b0;
    #1;
    chk("rstmid_write_drop", 32'(mem_write), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_words_done", 32'(words_done), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_w32", mem[32], 32'd0);
    chk("rstmid_w33", mem[33], 32'd1);
    chk("rstmid_w34_untouched", mem[34], 32'd34);
    chk("rstmid_w35_untouched", mem[35], 32'd35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-granular copy/fill engine that acts as the initiator on the single-port data memory interface: write strobe, 32-bit byte address, 32-bit write data, and combinational read data. A control agent such as a testbench, debug port or future CPU-side controller programs source, destination, length and mode, then pulses `start`. The engine then autonomously reads and writes memory and reports completion. It sits between that control agent and the data memory, which it owns while busy.

## Interface
- `LEN_W`, 7: width of the length field, in words (0..64).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `mode` in 1: 0 = copy, 1 = fill; captured at start.
- `src_addr` in 32: source byte address (copy mode); captured at start.
- `dst_addr` in 32: destination byte address; captured at start.
- `len` in LEN_W: number of words; captured at start.
- `fill_data` in 32: pattern written in fill mode; captured at start.
- `busy` out 1: high while a transfer is active.
- `done` out 1: one-cycle completion pulse.
- `words_done` out LEN_W: count of words written so far in the current transfer.
- `mem_write` out 1: memory write strobe.
- `mem_address` out 32: memory byte address.
- `mem_write_data` out 32: memory write data.
- `mem_read_data` in 32: memory read data, combinational from `mem_address`.

## Operation
- FSM states: IDLE, READ, WRITE, FILL, DONE.
- **IDLE**
  - If `start` is high: capture all inputs, force `src[1:0]` and `dst[1:0]` to 0, clear `words_done`.
  - Next state: DONE if `len == 0`; else FILL if `mode == 1`; else READ.
- **READ**
  - Drive `mem_address = src` and `mem_write = 0`.
  - At the edge, latch `mem_read_data` into the hold register, then go to WRITE.
- **WRITE**
  - Drive `mem_address = dst`, `mem_write_data = hold`, `mem_write = 1`.
  - At the edge: `src += 4`, `dst += 4`, `words_done += 1`.
  - Then go to DONE if `words_done + 1 == len`, else READ.
- **FILL**
  - Drive `mem_address = dst`, `mem_write_data = fill_data`, `mem_write = 1`.
  - At the edge: `dst += 4`, `words_done += 1`.
  - Stay in FILL until the last word is written, then go to DONE.
- **DONE**
  - `done = 1` for this one cycle; unconditionally return to IDLE.
  - `start` is ignored in DONE.
- Address arithmetic is modulo 2^32; incrementing past 0xFFFFFFFC wraps to 0.
- Copies always run in ascending order.
  - A forward overlap (`src < dst < src + 4*len`) propagates already-written words. This is defined behaviour, not an error.
- `start` in any state other than IDLE is ignored; captured parameters are unaffected.
- Input changes after capture have no effect until the next accepted start.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `mem_write` = 0; `mem_address`, `mem_write_data`, `words_done`, hold register = 0.
- **Outputs**
  - `busy` = 1 in READ, WRITE and FILL.
  - `mem_*` outputs decode from registered state only; there is no combinational path from `start`.
  - `mem_write` is 0 in IDLE and DONE.
- **Latency** (start sampled at edge 0):
  - Copy: the first READ occupies cycle 1. Each word takes 2 cycles. `done` is high in cycle 2·len+1.
  - Fill: each word takes 1 cycle. `done` is high in cycle len+1.
  - `len == 0`: `done` is high in cycle 1 with no memory access.
- Back-to-back transfers: the earliest accepted next start is the edge after the DONE cycle, i.e. while in IDLE.
- **Reset mid-transfer**
  - `mem_write` drops immediately (asynchronously).
  - No partial or extra write is issued. Words completed before reset remain written.

## Structure
- Shared package `mem_dma_pkg`:
  - state enum;
  - `MODE_COPY` / `MODE_FILL` constants;
  - `WORD_BYTES = 4`;
  - `MEM_WORDS = 64`.
- Single module, no sub-module.
- The address/count registers are one small always block. The FSM is a second always block, and output decode is combinational from state.

## Test plan
All scenarios use memory preloaded with word *i* = *i*.
- **Basic copy:** copy, src=0x00, dst=0x80, len=4 → words 32..35 = 0,1,2,3. `busy` is high cycles 1–8, `done` in cycle 9, `words_done` = 4.
- **Fill:** fill, dst=0x10, len=3, fill_data=0xDEADBEEF → words 4..6 = 0xDEADBEEF. `mem_write` is high cycles 1–3, `done` in cycle 4.
- **Zero length / misaligned:**
  - len=0 → `done` in cycle 1, `mem_write` never asserted.
  - src=0x03 is treated as 0x00.
- **Start while busy:** a second `start` with different parameters during a busy copy → ignored; the first transfer's results and timing are unchanged.
- **Forward overlap:** copy, src=0x00, dst=0x04, len=3 → words 1..3 = 0,0,0; word 0 unchanged.
- **Reset mid-transfer:** assert `rst_n` low during the 3rd WRITE cycle of a len=5 copy → `mem_write` drops at once, `busy` = 0, and only the first two destination words are modified.
